// File: rtl/mux21_lanes.sv
// Two-lane byte serializer: captures an (in0, in1) pair every other cycle and
// emits lane 0 then lane 1 on out/valid_out, gated by an IDLE/RUN activity FSM.
module mux21_lanes (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [1:0] valid_in,
    output logic       in_ready,
    output logic [7:0] out,
    output logic       valid_out,
    output logic [7:0] tx_count,
    output logic       lane_err
);

    localparam int unsigned W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           phase_q, phase_d;
    logic [W-1:0]   h0_q, h0_d;
    logic [W-1:0]   h1_q, h1_d;
    logic [1:0]     hv_q, hv_d;
    logic           zero_q, zero_d;
    logic [W-1:0]   out_q, out_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic           err_q, err_d;

    logic           lane_vld;
    logic [W-1:0]   lane_byte;
    logic           emit;

    // Phase 1 edges capture a new pair and emit the previous pair's lane 1;
    // phase 0 edges emit lane 0 of the pair currently held.
    always_comb begin
        state_d   = state_q;
        phase_d   = ~phase_q;
        h0_d      = h0_q;
        h1_d      = h1_q;
        hv_d      = hv_q;
        zero_d    = zero_q;
        out_d     = out_q;
        cnt_d     = cnt_q;
        err_d     = err_q;

        lane_vld  = phase_q ? hv_q[1] : hv_q[0];
        lane_byte = phase_q ? h1_q : h0_q;
        emit      = (state_q == RUN) && lane_vld;

        valid_d   = emit;
        if (emit) begin
            out_d = lane_byte;
            cnt_d = cnt_q + W'(1);
        end

        if (phase_q) begin
            h0_d   = in0;
            h1_d   = in1;
            hv_d   = valid_in;
            zero_d = (valid_in == 2'b00);
            if (valid_in == 2'b10) begin
                err_d = 1'b1;
            end
            unique case (state_q)
                IDLE: if (valid_in != 2'b00) state_d = RUN;
                RUN:  if (valid_in == 2'b00 && zero_q) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            h0_q    <= '0;
            h1_q    <= '0;
            hv_q    <= 2'b00;
            zero_q  <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            h0_q    <= h0_d;
            h1_q    <= h1_d;
            hv_q    <= hv_d;
            zero_q  <= zero_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = phase_q & ~reset;
    assign out       = out_q;
    assign valid_out = valid_q;
    assign tx_count  = cnt_q;
    assign lane_err  = err_q;

endmodule

// File: tb/tb_mux21_lanes.sv
// Directed bench for mux21_lanes: per-cycle vector table plus a 258-byte
// streaming run that exercises the tx_count wrap.
module tb_mux21_lanes;

    logic       clk;
    logic       reset;
    logic [7:0] in0, in1;
    logic [1:0] valid_in;
    logic       in_ready;
    logic [7:0] out;
    logic       valid_out;
    logic [7:0] tx_count;
    logic       lane_err;

    int checks;
    int failures;

    mux21_lanes dut (
        .clk      (clk),
        .reset    (reset),
        .in0      (in0),
        .in1      (in1),
        .valid_in (valid_in),
        .in_ready (in_ready),
        .out      (out),
        .valid_out(valid_out),
        .tx_count (tx_count),
        .lane_err (lane_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs applied before an edge, outputs expected just after it.
    typedef struct {
        logic       rst;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] v;
        logic [7:0] eo;
        logic       ev;
        logic [7:0] ec;
        logic       ee;
        logic       er;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] v);
        reset    = r;
        in0      = a;
        in1      = b;
        valid_in = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b1, 8'h00, 8'h00, 2'b00);

        //          rst   in0    in1    vin    out    vo    cnt    err   rdy
        vq.push_back('{1'b1, 8'h00, 8'h00, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
        vq.push_back('{1'b1, 8'h00, 8'h00, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
        vq.push_back('{1'b0, 8'h00, 8'h00, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'hFF, 8'hDD, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
        vq.push_back('{1'b0, 8'h12, 8'h34, 2'd3, 8'hFF, 1'b1, 8'h01, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'hEE, 8'hCC, 2'd3, 8'hDD, 1'b1, 8'h02, 1'b0, 1'b0});
        vq.push_back('{1'b0, 8'hDE, 8'hAD, 2'd2, 8'hEE, 1'b1, 8'h03, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'hBB, 8'h99, 2'd3, 8'hCC, 1'b1, 8'h04, 1'b0, 1'b0});
        vq.push_back('{1'b0, 8'h00, 8'h00, 2'd0, 8'hBB, 1'b1, 8'h05, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'hAA, 8'h88, 2'd3, 8'h99, 1'b1, 8'h06, 1'b0, 1'b0});
        vq.push_back('{1'b0, 8'h00, 8'h00, 2'd0, 8'hAA, 1'b1, 8'h07, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'h77, 8'h66, 2'd1, 8'h88, 1'b1, 8'h08, 1'b0, 1'b0});
        vq.push_back('{1'b0, 8'h00, 8'h00, 2'd0, 8'h77, 1'b1, 8'h09, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'h55, 8'h44, 2'd2, 8'h77, 1'b0, 8'h09, 1'b1, 1'b0});
        vq.push_back('{1'b0, 8'h00, 8'h00, 2'd0, 8'h77, 1'b0, 8'h09, 1'b1, 1'b1});
        vq.push_back('{1'b0, 8'h01, 8'h02, 2'd3, 8'h44, 1'b1, 8'h0A, 1'b1, 1'b0});
        vq.push_back('{1'b0, 8'h00, 8'h00, 2'd0, 8'h01, 1'b1, 8'h0B, 1'b1, 1'b1});
        vq.push_back('{1'b0, 8'h03, 8'h04, 2'd3, 8'h02, 1'b1, 8'h0C, 1'b1, 1'b0});
        vq.push_back('{1'b0, 8'h00, 8'h00, 2'd0, 8'h03, 1'b1, 8'h0D, 1'b1, 1'b1});
        vq.push_back('{1'b0, 8'hA0, 8'hA1, 2'd0, 8'h04, 1'b1, 8'h0E, 1'b1, 1'b0});
        vq.push_back('{1'b0, 8'h00, 8'h00, 2'd0, 8'h04, 1'b0, 8'h0E, 1'b1, 1'b1});
        vq.push_back('{1'b0, 8'hB0, 8'hB1, 2'd0, 8'h04, 1'b0, 8'h0E, 1'b1, 1'b0});
        vq.push_back('{1'b0, 8'h00, 8'h00, 2'd0, 8'h04, 1'b0, 8'h0E, 1'b1, 1'b1});
        vq.push_back('{1'b0, 8'h11, 8'h22, 2'd0, 8'h04, 1'b0, 8'h0E, 1'b1, 1'b0});
        vq.push_back('{1'b0, 8'h00, 8'h00, 2'd0, 8'h04, 1'b0, 8'h0E, 1'b1, 1'b1});
        vq.push_back('{1'b0, 8'h33, 8'h44, 2'd3, 8'h04, 1'b0, 8'h0E, 1'b1, 1'b0});
        vq.push_back('{1'b0, 8'h00, 8'h00, 2'd0, 8'h33, 1'b1, 8'h0F, 1'b1, 1'b1});
        vq.push_back('{1'b0, 8'h5A, 8'h5B, 2'd3, 8'h44, 1'b1, 8'h10, 1'b1, 1'b0});
        vq.push_back('{1'b0, 8'h00, 8'h00, 2'd0, 8'h5A, 1'b1, 8'h11, 1'b1, 1'b1});
        vq.push_back('{1'b1, 8'h99, 8'h99, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
        vq.push_back('{1'b0, 8'h00, 8'h00, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'hC0, 8'hC1, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
        vq.push_back('{1'b0, 8'h00, 8'h00, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1});

        foreach (vq[i]) begin
            string tag;
            tag = $sformatf("row%0d", i);
            drive(vq[i].rst, vq[i].a, vq[i].b, vq[i].v);
            step();
            chk({tag, "_out"},       out,               vq[i].eo);
            chk({tag, "_valid_out"}, 8'(valid_out),     8'(vq[i].ev));
            chk({tag, "_tx_count"},  tx_count,          vq[i].ec);
            chk({tag, "_lane_err"},  8'(lane_err),      8'(vq[i].ee));
            chk({tag, "_in_ready"},  8'(in_ready),      8'(vq[i].er));
        end

        // Continuous stream of 129 full pairs from IDLE with tx_count at 0.
        for (int k = 0; k < 129; k++) begin
            drive(1'b0, 8'(2 * k), 8'(2 * k + 1), 2'b11);
            step();
            chk($sformatf("wrap_cap%0d_valid", k), 8'(valid_out), (k == 0) ? 8'h00 : 8'h01);
            chk($sformatf("wrap_cap%0d_cnt", k), tx_count, 8'(2 * k));
            if (k > 0) chk($sformatf("wrap_cap%0d_out", k), out, 8'(2 * k - 1));
            drive(1'b0, 8'h00, 8'h00, 2'b00);
            step();
            chk($sformatf("wrap_l0_%0d_valid", k), 8'(valid_out), 8'h01);
            chk($sformatf("wrap_l0_%0d_out", k), out, 8'(2 * k));
            chk($sformatf("wrap_l0_%0d_cnt", k), tx_count, 8'(2 * k + 1));
        end
        drive(1'b0, 8'h00, 8'h00, 2'b00);
        step();
        chk("wrap_final_out",   out,             8'h01);
        chk("wrap_final_valid", 8'(valid_out),   8'h01);
        chk("wrap_final_cnt",   tx_count,        8'h02);
        chk("wrap_final_err",   8'(lane_err),    8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
